// File: rtl/seq_alu_v2.sv
// Handshaked sequential integer ALU: 1-cycle simple ops, iterative MUL/DIV/REM.
// Optional sticky flag accumulator enabled by defining SEQ_ALU_STICKY_FLAGS_EN.
module seq_alu_v2 #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             overflow,
    output logic             negative,
    output logic             zero,
    output logic             cout,
    output logic             div_zero,
    output logic             illegal,
    output logic             busy
`ifdef SEQ_ALU_STICKY_FLAGS_EN
    ,
    input  logic             flag_clr,
    output logic [4:0]       sticky_flags
`endif
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SAR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;
    localparam logic [3:0] OP_REM = 4'd12;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             accept;
    logic             iter_op;
    logic [SH_W-1:0]  sh;
    logic             cmp_lt;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;

    logic [WIDTH-1:0] sc_r;
    logic             sc_ovf;
    logic             sc_cout;
    logic             sc_ill;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] fin_r;
    logic             fin_ovf;
    logic             fin_dz;

    assign accept   = in_valid && in_ready;
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign iter_op  = (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    assign sh       = y[SH_W-1:0];
    assign cmp_lt   = signed_mode ? ($signed(x) < $signed(y)) : (x < y);
    assign add_sum  = {1'b0, x} + {1'b0, y};
    assign sub_diff = {1'b0, x} - {1'b0, y};

    // Single-cycle result, evaluated straight from the live operands.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        sc_r    = '0;
        sc_ovf  = 1'b0;
        sc_cout = 1'b0;
        sc_ill  = 1'b0;
        case (op)
            OP_ADD: begin
                sc_r    = add_sum[WIDTH-1:0];
                sc_cout = add_sum[WIDTH];
                sc_ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (add_sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                sc_r    = sub_diff[WIDTH-1:0];
                sc_cout = ~sub_diff[WIDTH];
                sc_ovf  = (x[WIDTH-1] != y[WIDTH-1]) && (sub_diff[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND: sc_r = x & y;
            OP_OR:  sc_r = x | y;
            OP_XOR: sc_r = x ^ y;
            OP_NOT: sc_r = ~x;
            OP_SHL: sc_r = x << sh;
            OP_SHR: sc_r = x >> sh;
            OP_SAR: sc_r = $signed(x) >>> sh;
            OP_CMP: sc_r = {{(WIDTH-1){1'b0}}, cmp_lt};
            OP_MUL, OP_DIV, OP_REM: sc_r = '0;
            default: sc_ill = 1'b1;
        endcase
    end

    // One iteration: acc_lo holds the multiplier (MUL) or the dividend/quotient
    // (DIV/REM); acc_hi holds the partial product high half or the remainder.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_rem   = div_shift[WIDTH-1:0] - opnd_q;

    always_comb begin
        step_hi = '0;
        step_lo = '0;
        if (op_q == OP_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else if (div_ge) begin
            step_hi = div_rem;
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    // A zero divisor needs no special case: every trial subtract succeeds,
    // giving an all-ones quotient and shifting the dividend into the remainder.
    assign fin_r   = (op_q == OP_REM) ? step_hi : step_lo;
    assign fin_ovf = (op_q == OP_MUL) && (step_hi != '0);
    assign fin_dz  = (op_q != OP_MUL) && (opnd_q == '0);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            r         <= '0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            cout      <= 1'b0;
            div_zero  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (iter_op) begin
                            // MUL is commutative, so both iterative kinds load x/y the same way.
                            state     <= BUSY;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                            cnt       <= CNT_W'(WIDTH);
                            op_q      <= op;
                            acc_hi    <= '0;
                            acc_lo    <= x;
                            opnd_q    <= y;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            r         <= sc_r;
                            overflow  <= sc_ovf;
                            negative  <= sc_r[WIDTH-1];
                            zero      <= (sc_r == '0);
                            cout      <= sc_cout;
                            div_zero  <= 1'b0;
                            illegal   <= sc_ill;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        r         <= fin_r;
                        overflow  <= fin_ovf;
                        negative  <= fin_r[WIDTH-1];
                        zero      <= (fin_r == '0);
                        cout      <= 1'b0;
                        div_zero  <= fin_dz;
                        illegal   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_ALU_STICKY_FLAGS_EN
    // Clear takes priority over a delivery in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flag_clr) begin
            sticky_flags <= '0;
        end else if (out_valid && out_ready) begin
            sticky_flags <= sticky_flags | {overflow, cout, div_zero, illegal, zero};
        end
    end
`endif

endmodule
